// File: rtl/rv_hazard_unit_pkg.sv
// Shared types and helpers for the RV pipeline hazard controller.
package rv_hazard_unit_pkg;

  localparam int REG_W = 5;

  // Bypass mux select: 0 reads the register file, k+1 selects bypass source k
  localparam int BP_DIRECT   = 0;
  localparam int BP_SRC_BASE = 1;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_LOAD = 2'd1,
    S_BUS  = 2'd2,
    S_HALT = 2'd3
  } hazard_state_t;

  // Mux code for bypass source k
  function automatic int bp_code(input int k);
    return BP_SRC_BASE + k;
  endfunction

  // True when a producer writes the consumer's register; x0 never counts
  function automatic logic reg_hit(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/rv_hazard_fwd_sel.sv
// Priority bypass encoder for one exec operand: the lowest-index (youngest)
// enabled source whose rd matches wins.
module rv_hazard_fwd_sel
  import rv_hazard_unit_pkg::*;
#(
  parameter int FWD_SRCS = 3,
  parameter int BP_W     = 2
) (
  input  logic [REG_W-1:0]                rs,
  input  logic [FWD_SRCS-1:0][REG_W-1:0]  fwd_rd,
  input  logic [FWD_SRCS-1:0]             fwd_we,
  output logic [BP_W-1:0]                 bp
);

  // Scan oldest to youngest so the youngest matching writer overrides
  always_comb begin
    bp = BP_W'(BP_DIRECT);
    for (int k = FWD_SRCS - 1; k >= 0; k--)
      if (fwd_we[k] && reg_hit(fwd_rd[k], rs)) bp = BP_W'(bp_code(k));
  end

endmodule

// File: rtl/rv_hazard_unit.sv
// Pipeline hazard controller: operand bypass select, ALU/load-use stalls,
// branch and post-reset flushes, sticky halt on an illegal instruction.
// Optional feature: define RV_HAZ_PERF_CNT_EN to add saturating stall/flush
// performance counters.
module rv_hazard_unit
  import rv_hazard_unit_pkg::*;
#(
  parameter int EXEC_STAGES = 2,
  parameter int FWD_SRCS    = 3,
  parameter int LOAD_LAT    = 1,
  parameter int RST_FLUSH   = 2,
  localparam int BP_W       = $clog2(FWD_SRCS + 1)
) (
  input  logic                               i_clk,
  input  logic                               i_reset_n,
  input  logic                               i_fetch_bus_ack,
  input  logic [REG_W-1:0]                   i_decode_rs1,
  input  logic [REG_W-1:0]                   i_decode_rs2,
  input  logic                               i_decode_inv,
  input  logic [EXEC_STAGES-1:0][REG_W-1:0]  i_exec_rd,
  input  logic                               i_exec_load,
  input  logic [REG_W-1:0]                   i_exec_rs1,
  input  logic [REG_W-1:0]                   i_exec_rs2,
  input  logic                               i_exec_pc_sel,
  input  logic [FWD_SRCS-1:0][REG_W-1:0]     i_fwd_rd,
  input  logic [FWD_SRCS-1:0]                i_fwd_we,
  output logic [BP_W-1:0]                    o_exec_bp_rs1,
  output logic [BP_W-1:0]                    o_exec_bp_rs2,
  output logic                               o_fetch_stall,
  output logic                               o_decode_stall,
  output logic                               o_decode_flush,
  output logic [EXEC_STAGES-1:0]             o_exec_flush,
`ifdef RV_HAZ_PERF_CNT_EN
  output logic [31:0]                        o_perf_stall_cnt,
  output logic [31:0]                        o_perf_flush_cnt,
`endif
  output logic                               o_inv_instr
);

  localparam int RCNT_W = (RST_FLUSH > 0) ? $clog2(RST_FLUSH + 1) : 1;

  hazard_state_t             state, state_nx;
  logic [2:0]                lcnt, lcnt_nx;
  logic [RCNT_W-1:0]         rst_cnt;
  logic [EXEC_STAGES-1:0]    inv_pipe, inv_pipe_nx;
  logic                      rst_seq, halt, load_use, alu_haz, fsm_stall;
  logic                      fetch_stall_c, decode_stall_c, decode_flush_c;
  logic [EXEC_STAGES-1:0]    ef_c;
  logic [BP_W-1:0]           bp_rs1, bp_rs2;

  // The last exec stage's rd only feeds the bypass network, not ALU hazards
  logic unused_last_rd;
  assign unused_last_rd = ^i_exec_rd[EXEC_STAGES-1];

  rv_hazard_fwd_sel #(.FWD_SRCS(FWD_SRCS), .BP_W(BP_W)) u_fwd_rs1 (
    .rs(i_exec_rs1), .fwd_rd(i_fwd_rd), .fwd_we(i_fwd_we), .bp(bp_rs1)
  );
  rv_hazard_fwd_sel #(.FWD_SRCS(FWD_SRCS), .BP_W(BP_W)) u_fwd_rs2 (
    .rs(i_exec_rs2), .fwd_rd(i_fwd_rd), .fwd_we(i_fwd_we), .bp(bp_rs2)
  );

  assign rst_seq  = (rst_cnt != '0);
  assign halt     = (state == S_HALT);
  assign load_use = i_exec_load &&
                    (reg_hit(i_exec_rd[0], i_decode_rs1) || reg_hit(i_exec_rd[0], i_decode_rs2));

  // Decode operand still being computed in a non-final exec stage
  always_comb begin
    alu_haz = 1'b0;
    for (int j = 0; j < EXEC_STAGES - 1; j++)
      if (reg_hit(i_exec_rd[j], i_decode_rs1) || reg_hit(i_exec_rd[j], i_decode_rs2))
        alu_haz = 1'b1;
  end

  // Load-use / bus-wait FSM; a taken branch squashes the stalled younger
  // instruction, and a retiring illegal instruction overrides everything
  always_comb begin
    state_nx  = state;
    lcnt_nx   = lcnt;
    fsm_stall = 1'b0;
    case (state)
      S_RUN: begin
        if (!i_exec_pc_sel && load_use) begin
          state_nx  = S_LOAD;
          lcnt_nx   = 3'(LOAD_LAT - 1);
          fsm_stall = 1'b1;
        end
      end
      S_LOAD: begin
        if (i_exec_pc_sel) state_nx = S_RUN;
        else begin
          fsm_stall = 1'b1;
          if (lcnt == '0) state_nx = i_fetch_bus_ack ? S_RUN : S_BUS;
          else            lcnt_nx  = lcnt - 3'd1;
        end
      end
      S_BUS: begin
        if (i_exec_pc_sel) state_nx = S_RUN;
        else begin
          fsm_stall = 1'b1;
          if (i_fetch_bus_ack) state_nx = S_RUN;
        end
      end
      default: ;
    endcase
    if (inv_pipe[EXEC_STAGES-1]) state_nx = S_HALT;
  end

  // Illegal-instruction tracker walks alongside the exec stages
  always_comb begin
    inv_pipe_nx    = inv_pipe << 1;
    inv_pipe_nx[0] = i_decode_inv & ~decode_flush_c;
    if (i_exec_pc_sel) inv_pipe_nx = '0;
  end

  // State, counters and invalid pipe
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state    <= S_RUN;
      lcnt     <= '0;
      rst_cnt  <= RCNT_W'(RST_FLUSH);
      inv_pipe <= '0;
    end else begin
      state    <= state_nx;
      lcnt     <= lcnt_nx;
      inv_pipe <= inv_pipe_nx;
      if (rst_seq) rst_cnt <= rst_cnt - 1'b1;
    end
  end

  // Stall / flush combination ahead of the reset override
  always_comb begin
    fetch_stall_c  = halt | fsm_stall | ((state == S_RUN) && !i_exec_pc_sel && alu_haz);
    decode_stall_c = fetch_stall_c | ((state == S_RUN) && !i_exec_pc_sel && !i_fetch_bus_ack);
    decode_flush_c = i_exec_pc_sel | halt | rst_seq;
  end

  // Stage 0 takes the bubble behind a decode stall; the final stage holds the
  // branch itself so only the reset sequencer clears it
  for (genvar j = 0; j < EXEC_STAGES; j++) begin : g_ef
    if (j == 0 && EXEC_STAGES > 1) begin : g_first
      assign ef_c[j] = decode_stall_c | i_exec_pc_sel | rst_seq;
    end else if (j == 0) begin : g_only
      assign ef_c[j] = decode_stall_c | rst_seq;
    end else if (j == EXEC_STAGES - 1) begin : g_last
      assign ef_c[j] = rst_seq;
    end else begin : g_mid
      assign ef_c[j] = i_exec_pc_sel | rst_seq;
    end
  end

  // While reset is held the pipe is quiesced: everything flushed, no stalls
  always_comb begin
    o_fetch_stall  = i_reset_n & fetch_stall_c;
    o_decode_stall = i_reset_n & decode_stall_c;
    o_decode_flush = ~i_reset_n | decode_flush_c;
    o_exec_flush   = i_reset_n ? ef_c : '1;
    o_exec_bp_rs1  = i_reset_n ? bp_rs1 : BP_W'(BP_DIRECT);
    o_exec_bp_rs2  = i_reset_n ? bp_rs2 : BP_W'(BP_DIRECT);
    o_inv_instr    = halt;
  end

`ifdef RV_HAZ_PERF_CNT_EN
  // Saturating counters of fetch-stall cycles and branch flushes
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_perf_stall_cnt <= '0;
      o_perf_flush_cnt <= '0;
    end else begin
      if (o_fetch_stall && (o_perf_stall_cnt != '1)) o_perf_stall_cnt <= o_perf_stall_cnt + 32'd1;
      if (i_exec_pc_sel && (o_perf_flush_cnt != '1)) o_perf_flush_cnt <= o_perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv_hazard_unit.sv
// Directed bench for rv_hazard_unit: combinational vector table plus
// hand-written multi-cycle sequences for load-use, bus wait and halt.
module tb_rv_hazard_unit;
  localparam int ES = 2, FS = 3, LL = 2, RF = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            ack, d_inv, e_load, pc_sel;
  logic [4:0]      d_rs1, d_rs2, e_rs1, e_rs2;
  logic [ES-1:0][4:0] e_rd;
  logic [FS-1:0][4:0] f_rd;
  logic [FS-1:0]   f_we;
  logic [1:0]      bp1, bp2;
  logic            fst, dst, dfl, inv;
  logic [ES-1:0]   efl;
`ifdef RV_HAZ_PERF_CNT_EN
  logic [31:0]     p_stall, p_flush;
`endif

  rv_hazard_unit #(.EXEC_STAGES(ES), .FWD_SRCS(FS), .LOAD_LAT(LL), .RST_FLUSH(RF)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_fetch_bus_ack(ack),
    .i_decode_rs1(d_rs1), .i_decode_rs2(d_rs2), .i_decode_inv(d_inv),
    .i_exec_rd(e_rd), .i_exec_load(e_load), .i_exec_rs1(e_rs1), .i_exec_rs2(e_rs2),
    .i_exec_pc_sel(pc_sel), .i_fwd_rd(f_rd), .i_fwd_we(f_we),
    .o_exec_bp_rs1(bp1), .o_exec_bp_rs2(bp2), .o_fetch_stall(fst), .o_decode_stall(dst),
    .o_decode_flush(dfl), .o_exec_flush(efl),
`ifdef RV_HAZ_PERF_CNT_EN
    .o_perf_stall_cnt(p_stall), .o_perf_flush_cnt(p_flush),
`endif
    .o_inv_instr(inv)
  );

  typedef struct {
    logic [4:0] d_rs1, d_rs2, erd0, erd1, e_rs1, e_rs2;
    logic [2:0] we;
    logic [4:0] rd2, rd1, rd0;
    logic       pc, ack;
    logic [1:0] bp1, bp2;
    logic       fst, dst, dfl;
    logic [1:0] efl;
  } vec_t;

  vec_t tv[12];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    ack = 1'b1; d_inv = 1'b0; e_load = 1'b0; pc_sel = 1'b0;
    d_rs1 = '0; d_rs2 = '0; e_rs1 = '0; e_rs2 = '0;
    e_rd = '0; f_rd = '0; f_we = '0;
  endtask

  // Next cycle: new inputs go in just after the falling edge
  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic chk_st(input string nm, input int f, input int d);
    chk({nm, " fetch_stall"}, int'(fst), f);
    chk({nm, " decode_stall"}, int'(dst), d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{0,0,0,0, 5,7, 3'b110, 5,5,7, 0,1, 2,0, 0,0,0, 2'b00};
    tv[1]  = '{0,0,0,0, 0,0, 3'b111, 0,0,0, 0,1, 0,0, 0,0,0, 2'b00};
    tv[2]  = '{0,0,0,0, 4,4, 3'b111, 4,4,4, 0,1, 1,1, 0,0,0, 2'b00};
    tv[3]  = '{0,0,0,0, 9,1, 3'b100, 9,9,0, 0,1, 3,0, 0,0,0, 2'b00};
    tv[4]  = '{0,0,0,0, 8,6, 3'b011, 0,8,6, 0,1, 2,1, 0,0,0, 2'b00};
    tv[5]  = '{10,0,10,0, 0,0, 3'b000, 0,0,0, 0,1, 0,0, 1,1,0, 2'b01};
    tv[6]  = '{0,11,11,0, 0,0, 3'b000, 0,0,0, 0,1, 0,0, 1,1,0, 2'b01};
    tv[7]  = '{12,0,0,12, 0,0, 3'b000, 0,0,0, 0,1, 0,0, 0,0,0, 2'b00};
    tv[8]  = '{0,0,0,0, 0,0, 3'b000, 0,0,0, 0,1, 0,0, 0,0,0, 2'b00};
    tv[9]  = '{10,0,10,0, 0,0, 3'b000, 0,0,0, 1,1, 0,0, 0,0,1, 2'b01};
    tv[10] = '{0,0,0,0, 0,0, 3'b000, 0,0,0, 0,0, 0,0, 0,1,0, 2'b01};
    tv[11] = '{0,0,0,0, 3,0, 3'b001, 0,0,3, 1,1, 1,0, 0,0,1, 2'b01};

    // Held reset: matching bypass input must still give bp=0
    idle();
    rst_n = 1'b0; e_rs1 = 5'd5; f_we = 3'b001; f_rd[0] = 5'd5; d_rs1 = 5'd1; e_rd[0] = 5'd1;
    repeat (2) @(negedge clk);
    #2;
    chk_st("reset", 0, 0);
    chk("reset decode_flush", int'(dfl), 1);
    chk("reset exec_flush", int'(efl), 3);
    chk("reset bp_rs1", int'(bp1), 0);
    chk("reset inv_instr", int'(inv), 0);

    // Release: two cycles of flush, then clear
    nxt(); rst_n = 1'b1; #2;
    chk("rel0 decode_flush", int'(dfl), 1);
    chk("rel0 exec_flush", int'(efl), 3);
    chk_st("rel0", 0, 0);
    nxt(); #2;
    chk("rel1 decode_flush", int'(dfl), 1);
    nxt(); #2;
    chk("rel2 decode_flush", int'(dfl), 0);
    chk("rel2 exec_flush", int'(efl), 0);

    for (int i = 0; i < 12; i++) begin
      nxt();
      d_rs1 = tv[i].d_rs1; d_rs2 = tv[i].d_rs2;
      e_rd[0] = tv[i].erd0; e_rd[1] = tv[i].erd1;
      e_rs1 = tv[i].e_rs1; e_rs2 = tv[i].e_rs2;
      f_we = tv[i].we; f_rd[2] = tv[i].rd2; f_rd[1] = tv[i].rd1; f_rd[0] = tv[i].rd0;
      pc_sel = tv[i].pc; ack = tv[i].ack;
      #2;
      chk($sformatf("tv%0d bp_rs1", i), int'(bp1), int'(tv[i].bp1));
      chk($sformatf("tv%0d bp_rs2", i), int'(bp2), int'(tv[i].bp2));
      chk($sformatf("tv%0d fetch_stall", i), int'(fst), int'(tv[i].fst));
      chk($sformatf("tv%0d decode_stall", i), int'(dst), int'(tv[i].dst));
      chk($sformatf("tv%0d decode_flush", i), int'(dfl), int'(tv[i].dfl));
      chk($sformatf("tv%0d exec_flush", i), int'(efl), int'(tv[i].efl));
    end

    // Load-use, ack high: hit cycle plus LOAD_LAT cycles in S_LOAD
    nxt(); e_load = 1'b1; e_rd[0] = 5'd3; d_rs2 = 5'd3; #2;
    chk_st("lu hit", 1, 1);
    chk("lu hit exec_flush0", int'(efl[0]), 1);
    for (int c = 1; c <= LL; c++) begin
      nxt(); #2;
      chk_st($sformatf("lu wait%0d", c), 1, 1);
      chk($sformatf("lu wait%0d exec_flush0", c), int'(efl[0]), 1);
    end
    nxt(); #2;
    chk_st("lu done", 0, 0);

    // Load-use with bus not ready until cycle 4
    nxt(); ack = 1'b0; e_load = 1'b1; e_rd[0] = 5'd3; d_rs2 = 5'd3; #2;
    chk_st("bus c0", 1, 1);
    for (int c = 1; c <= 3; c++) begin
      nxt(); ack = 1'b0; #2;
      chk_st($sformatf("bus c%0d", c), 1, 1);
    end
    nxt(); #2;
    chk_st("bus c4 ack", 1, 1);
    nxt(); #2;
    chk_st("bus c5", 0, 0);

    // Load-use colliding with a taken branch: no stall, FSM stays in S_RUN
    nxt(); e_load = 1'b1; e_rd[0] = 5'd3; d_rs2 = 5'd3; pc_sel = 1'b1; #2;
    chk_st("lu+br", 0, 0);
    chk("lu+br decode_flush", int'(dfl), 1);
    nxt(); #2;
    chk_st("lu+br after", 0, 0);

    // Branch arriving while in S_LOAD drops stalls that same cycle
    nxt(); e_load = 1'b1; e_rd[0] = 5'd3; d_rs1 = 5'd3; #2;
    chk_st("ld br hit", 1, 1);
    nxt(); pc_sel = 1'b1; #2;
    chk_st("ld br kill", 0, 0);
    nxt(); #2;
    chk_st("ld br after", 0, 0);

    // Illegal instruction squashed by a branch never halts
    nxt(); d_inv = 1'b1; #2;
    nxt(); pc_sel = 1'b1; #2;
    for (int c = 0; c < 3; c++) begin
      nxt(); #2;
      chk($sformatf("inv squash%0d inv_instr", c), int'(inv), 0);
      chk($sformatf("inv squash%0d fetch_stall", c), int'(fst), 0);
    end

    // Illegal instruction reaching the last stage halts
    nxt(); d_inv = 1'b1; #2;
    nxt(); #2;
    chk("inv c1 inv_instr", int'(inv), 0);
    nxt(); #2;
    chk("inv c2 inv_instr", int'(inv), 0);
    nxt(); #2;
    chk("inv c3 inv_instr", int'(inv), 1);
    chk_st("inv c3", 1, 1);
    chk("inv c3 decode_flush", int'(dfl), 1);
    nxt(); pc_sel = 1'b1; #2;
    chk("halt+br inv_instr", int'(inv), 1);
    chk_st("halt+br", 1, 1);

    // Only reset leaves halt
    nxt(); rst_n = 1'b0;
    nxt(); #2;
    chk("rst clears inv_instr", int'(inv), 0);
    chk_st("rst after halt", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
